// File: rtl/uart_pkt_deframer.sv
// Parses SYNC/CMD/LEN/payload/CHK packets from the UART byte stream into tagged 16-bit words.
// Words are queued in a small FIFO; checksum, command, timeout and overflow errors are reported.
module uart_pkt_deframer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RxData,
    input  logic        isNewData,
    output logic [15:0] word_data,
    output logic        word_is_wt,
    output logic [1:0]  word_pe,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [2:0]  err_code,
    output logic        busy,
    output logic [2:0]  state_tap
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        LEN    = 3'd2,
        PAY_HI = 3'd3,
        PAY_LO = 3'd4,
        CHK    = 3'd5
    } stateT;

    stateT       state, stateNext;
    logic        isWt, isWtNext;
    logic [1:0]  pe, peNext;
    logic [7:0]  remaining, remainingNext;
    logic [7:0]  hiByte, hiByteNext;
    logic [7:0]  checksum, checksumNext;
    logic        overflow, overflowNext;
    logic [TW-1:0] toCount, toCountNext;
    logic        doneNext, errNext;
    logic [2:0]  errCodeNext;
    logic        pushReq;
    logic [15:0] pushWord;

    logic [18:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   count;
    logic          full, doPop, doPush;
    logic [18:0]   head;

    assign full   = (count == (AW+1)'(FIFO_DEPTH));
    assign doPop  = word_valid && word_ready;
    // A full FIFO still takes a word when the head leaves on the same edge
    assign doPush = pushReq && (!full || doPop);

    assign head       = mem[rdPtr];
    assign word_valid = (count != '0);
    assign word_data  = word_valid ? head[15:0] : 16'h0000;
    assign word_pe    = word_valid ? head[17:16] : 2'b00;
    assign word_is_wt = word_valid ? head[18] : 1'b0;
    assign busy       = (state != IDLE);
    assign state_tap  = state;

    always_comb begin
        stateNext     = state;
        isWtNext      = isWt;
        peNext        = pe;
        remainingNext = remaining;
        hiByteNext    = hiByte;
        checksumNext  = checksum;
        overflowNext  = overflow;
        toCountNext   = toCount;
        doneNext      = 1'b0;
        errNext       = 1'b0;
        errCodeNext   = err_code;
        pushReq       = 1'b0;
        pushWord      = {hiByte, RxData};

        if (isNewData)
            toCountNext = '0;
        else if (state != IDLE)
            toCountNext = toCount + TW'(1);

        if (isNewData) begin
            case (state)
                IDLE: begin
                    if (RxData == SYNC_BYTE) begin
                        stateNext    = CMD;
                        overflowNext = 1'b0;
                    end
                end
                CMD: begin
                    if (RxData[7:4] == 4'h0 && (RxData[1:0] == 2'b01 || RxData[1:0] == 2'b10)) begin
                        isWtNext     = (RxData[1:0] == 2'b01);
                        peNext       = RxData[3:2];
                        checksumNext = RxData;
                        stateNext    = LEN;
                    end else begin
                        errNext     = 1'b1;
                        errCodeNext = 3'd2;
                        stateNext   = IDLE;
                    end
                end
                LEN: begin
                    remainingNext = RxData;
                    checksumNext  = checksum ^ RxData;
                    stateNext     = (RxData == 8'd0) ? CHK : PAY_HI;
                end
                PAY_HI: begin
                    hiByteNext   = RxData;
                    checksumNext = checksum ^ RxData;
                    stateNext    = PAY_LO;
                end
                PAY_LO: begin
                    pushReq       = 1'b1;
                    checksumNext  = checksum ^ RxData;
                    remainingNext = remaining - 8'd1;
                    stateNext     = (remaining == 8'd1) ? CHK : PAY_HI;
                end
                CHK: begin
                    stateNext = IDLE;
                    if (overflow) begin
                        errNext     = 1'b1;
                        errCodeNext = 3'd4;
                    end else if (checksum != RxData) begin
                        errNext     = 1'b1;
                        errCodeNext = 3'd1;
                    end else begin
                        doneNext    = 1'b1;
                        errCodeNext = 3'd0;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end else if (state != IDLE && toCount == TW'(TIMEOUT_CYC - 1)) begin
            stateNext   = IDLE;
            errNext     = 1'b1;
            errCodeNext = 3'd3;
            toCountNext = '0;
        end

        if (pushReq && full && !doPop)
            overflowNext = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            isWt      <= 1'b0;
            pe        <= 2'b00;
            remaining <= 8'd0;
            hiByte    <= 8'd0;
            checksum  <= 8'd0;
            overflow  <= 1'b0;
            toCount   <= '0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= 3'd0;
        end else begin
            state     <= stateNext;
            isWt      <= isWtNext;
            pe        <= peNext;
            remaining <= remainingNext;
            hiByte    <= hiByteNext;
            checksum  <= checksumNext;
            overflow  <= overflowNext;
            toCount   <= toCountNext;
            pkt_done  <= doneNext;
            pkt_err   <= errNext;
            err_code  <= errCodeNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush)
                wrPtr <= wrPtr + AW'(1);
            if (doPop)
                rdPtr <= rdPtr + AW'(1);
            if (doPush && !doPop)
                count <= count + (AW+1)'(1);
            else if (doPop && !doPush)
                count <= count - (AW+1)'(1);
        end
    end

    // Storage needs no reset: the outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (doPush && !reset)
            mem[wrPtr] <= {isWt, pe, pushWord};
    end

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Self-checking bench for uart_pkt_deframer: directed test-plan packets plus randomized packets
// compared against a queue-based packet model.
module tb_uart_pkt_deframer;

    localparam int DEPTH = 4;
    localparam int TOCYC = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  RxData;
    logic        isNewData;
    logic [15:0] word_data;
    logic        word_is_wt;
    logic [1:0]  word_pe;
    logic        word_valid;
    logic        word_ready;
    logic        pkt_done;
    logic        pkt_err;
    logic [2:0]  err_code;
    logic        busy;
    logic [2:0]  state_tap;

    int errors = 0;
    int checks = 0;
    int doneCnt = 0;
    int errCnt = 0;

    logic [18:0] expQ[$];
    logic [15:0] pktWords[$];

    always #5 clk = ~clk;

    uart_pkt_deframer #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYC(TOCYC),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .RxData(RxData),
        .isNewData(isNewData),
        .word_data(word_data),
        .word_is_wt(word_is_wt),
        .word_pe(word_pe),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .pkt_done(pkt_done),
        .pkt_err(pkt_err),
        .err_code(err_code),
        .busy(busy),
        .state_tap(state_tap)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic samplePulses();
        if (pkt_done === 1'b1) doneCnt++;
        if (pkt_err === 1'b1) errCnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        samplePulses();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        RxData = b;
        isNewData = 1'b1;
        @(posedge clk);
        #1;
        isNewData = 1'b0;
        RxData = 8'($urandom);
        samplePulses();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".valid"}, word_valid, 0);
        checkOutput({tag, ".data"}, word_data, 0);
        checkOutput({tag, ".isWt"}, word_is_wt, 0);
        checkOutput({tag, ".pe"}, word_pe, 0);
        checkOutput({tag, ".done"}, pkt_done, 0);
        checkOutput({tag, ".err"}, pkt_err, 0);
        checkOutput({tag, ".errCode"}, err_code, 0);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".state"}, state_tap, 0);
    endtask

    // Sends a whole packet built from pktWords; the model decides which words land and the outcome
    task automatic sendPacket(input string tag, input logic [7:0] cmd, input bit corrupt, input bit gaps);
        logic [7:0] chk;
        logic [7:0] len;
        logic [2:0] expCode;
        bit ovf;
        bit cmdOk;
        ovf = 1'b0;
        len = 8'(pktWords.size());
        cmdOk = (cmd[7:4] == 4'h0) && (cmd[1:0] == 2'b01 || cmd[1:0] == 2'b10);
        doneCnt = 0;
        errCnt = 0;
        applyStimulus(SYNC);
        if (gaps) idle($urandom_range(0, 3));
        applyStimulus(cmd);
        if (!cmdOk) begin
            checkOutput({tag, ".cmdErr"}, pkt_err, 1);
            checkOutput({tag, ".cmdCode"}, err_code, 2);
            checkOutput({tag, ".cmdBusy"}, busy, 0);
            checkOutput({tag, ".cmdDone"}, pkt_done, 0);
            return;
        end
        chk = cmd ^ len;
        applyStimulus(len);
        foreach (pktWords[i]) begin
            chk = chk ^ pktWords[i][15:8] ^ pktWords[i][7:0];
            if (gaps) idle($urandom_range(0, 3));
            applyStimulus(pktWords[i][15:8]);
            if (gaps) idle($urandom_range(0, 3));
            applyStimulus(pktWords[i][7:0]);
            if (expQ.size() < DEPTH)
                expQ.push_back({(cmd[1:0] == 2'b01), cmd[3:2], pktWords[i]});
            else
                ovf = 1'b1;
        end
        if (corrupt) chk = chk ^ 8'h01;
        expCode = ovf ? 3'd4 : (corrupt ? 3'd1 : 3'd0);
        if (gaps) idle($urandom_range(0, 3));
        applyStimulus(chk);
        checkOutput({tag, ".done"}, pkt_done, (expCode == 3'd0));
        checkOutput({tag, ".err"}, pkt_err, (expCode != 3'd0));
        checkOutput({tag, ".errCode"}, err_code, expCode);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".doneCount"}, doneCnt, (expCode == 3'd0) ? 1 : 0);
        checkOutput({tag, ".errCount"}, errCnt, (expCode != 3'd0) ? 1 : 0);
        tick();
        checkOutput({tag, ".pulseEnd"}, {pkt_done, pkt_err}, 0);
    endtask

    // Pops every modelled word with ready held high, expecting one word per cycle
    task automatic drainAll(input string tag);
        logic [18:0] exp;
        word_ready = 1'b1;
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkOutput({tag, ".valid"}, word_valid, 1);
            checkOutput({tag, ".word"}, {word_is_wt, word_pe, word_data}, exp);
            tick();
        end
        word_ready = 1'b0;
        checkOutput({tag, ".empty"}, word_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rcmd;
        int n;
        reset = 1'b1;
        isNewData = 1'b0;
        RxData = 8'h00;
        word_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        reset = 1'b0;
        idle(2);

        $display("[TB] valid weight packet");
        pktWords.delete();
        pktWords.push_back(16'h1234);
        pktWords.push_back(16'h5678);
        sendPacket("valid", 8'h05, 1'b0, 1'b0);
        drainAll("validDrain");

        $display("[TB] bad checksum");
        sendPacket("badChk", 8'h05, 1'b1, 1'b0);
        drainAll("badChkDrain");

        $display("[TB] bad command");
        pktWords.delete();
        sendPacket("badCmd", 8'h03, 1'b0, 1'b0);
        doneCnt = 0;
        errCnt = 0;
        applyStimulus(8'h01);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        idle(2);
        checkOutput("badCmd.tailIgnored", {busy, word_valid}, 0);
        checkOutput("badCmd.tailPulses", doneCnt + errCnt, 0);
        checkOutput("badCmd.codeHeld", err_code, 2);

        $display("[TB] garbage then empty packet");
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        checkOutput("garbage.busy", busy, 0);
        sendPacket("lenZero", 8'h09, 1'b0, 1'b0);
        checkOutput("lenZero.noWords", word_valid, 0);

        $display("[TB] overflow with back-pressure");
        pktWords.delete();
        repeat (5) pktWords.push_back(16'($urandom));
        sendPacket("overflow", 8'h0A, 1'b0, 1'b0);
        drainAll("overflowDrain");
        checkOutput("overflow.codeHeld", err_code, 4);

        $display("[TB] timeout");
        doneCnt = 0;
        errCnt = 0;
        applyStimulus(SYNC);
        applyStimulus(8'h06);
        applyStimulus(8'h01);
        applyStimulus(8'h12);
        idle(TOCYC - 1);
        checkOutput("timeout.notYet", {pkt_err, busy}, 2'b01);
        tick();
        checkOutput("timeout.err", pkt_err, 1);
        checkOutput("timeout.code", err_code, 3);
        checkOutput("timeout.busy", busy, 0);
        checkOutput("timeout.fifoEmpty", word_valid, 0);
        tick();
        checkOutput("timeout.pulseEnd", pkt_err, 0);

        $display("[TB] reset mid-payload");
        applyStimulus(SYNC);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        applyStimulus(8'hEF);
        checkOutput("midPkt.busy", busy, 1);
        checkOutput("midPkt.valid", word_valid, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkResetState("midReset");
        reset = 1'b0;
        expQ.delete();

        $display("[TB] randomized packets");
        for (int p = 0; p < 6; p++) begin
            rcmd = {4'h0, 2'($urandom), ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10};
            n = $urandom_range(1, 4);
            pktWords.delete();
            repeat (n) pktWords.push_back(16'($urandom));
            sendPacket("rand", rcmd, ($urandom_range(0, 2) == 0), 1'b1);
            drainAll("randDrain");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
